// File: rtl/cpu_defs_pkg.sv
// Shared CPU front-end definitions: widths, reset vector and the fetch packet.
package cpu_defs_pkg;
   localparam int              PC_W     = 32;
   localparam int              INST_W   = 32;
   localparam int              ROM_AW   = 10;
   localparam logic [PC_W-1:0] RESET_PC = 32'h0000_0000;
   localparam logic [PC_W-1:0] PC_INC   = 32'd4;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [PC_W-1:0]   pc;
   } fetch_pkt_t;
endpackage

// File: rtl/if_skid_buf.sv
// Output register plus one skid entry; the skid always drains ahead of new data.
module if_skid_buf #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         skid_valid
);
   logic [W-1:0] skid_q;
   logic         take;

   assign take = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (clr) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_q     <= '0;
      end else if (take) begin
         if (skid_valid) begin
            out_valid  <= 1'b1;
            out_data   <= skid_q;
            skid_valid <= in_valid;
            if (in_valid) skid_q <= in_data;
         end else begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
         end
      end else if (in_valid) begin
         // upstream issue throttling guarantees the skid is free here
         skid_valid <= 1'b1;
         skid_q     <= in_data;
      end
   end
endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: PC/issue control toward a 1-cycle ROM, skid-buffered decode handoff.
module if_fetch #(
   parameter int                         PC_W     = cpu_defs_pkg::PC_W,
   parameter int                         ROM_AW   = cpu_defs_pkg::ROM_AW,
   parameter int                         INST_W   = cpu_defs_pkg::INST_W,
   parameter logic [cpu_defs_pkg::PC_W-1:0] RESET_PC = cpu_defs_pkg::RESET_PC
) (
   input  logic              clk,
   input  logic              rst,
   output logic              rom_ce_o,
   output logic [ROM_AW-1:0] rom_addr_o,
   input  logic [INST_W-1:0] rom_data_i,
   input  logic              flush_i,
   input  logic [PC_W-1:0]   flush_pc_i,
   output logic [INST_W-1:0] inst_o,
   output logic [PC_W-1:0]   inst_pc_o,
   output logic              inst_valid_o,
   input  logic              id_ready_i
);
   import cpu_defs_pkg::*;

   logic [PC_W-1:0] fetch_pc, req_pc;
   logic            pending, skid_valid, fire, issue;
   logic [1:0]      occ;

   assign fire  = inst_valid_o & id_ready_i;
   assign occ   = 2'(inst_valid_o) + 2'(skid_valid) + 2'(pending);
   // fire never exceeds occ, so the subtraction cannot underflow
   assign issue = !rst && !flush_i && ((occ - 2'(fire)) < 2'd2);

   assign rom_ce_o   = issue;
   assign rom_addr_o = issue ? fetch_pc[ROM_AW+1:2] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= PC_W'(RESET_PC);
         req_pc   <= '0;
         pending  <= 1'b0;
      end else begin
         pending <= issue;
         if (flush_i) begin
            fetch_pc <= {flush_pc_i[PC_W-1:2], 2'b00};
         end else if (issue) begin
            fetch_pc <= fetch_pc + PC_W'(PC_INC);
            req_pc   <= fetch_pc;
         end
      end
   end

   if_skid_buf #(.W(INST_W + PC_W)) u_skid (
      .clk        (clk),
      .clr        (rst | flush_i),
      .in_valid   (pending & ~flush_i),
      .in_data    ({rom_data_i, req_pc}),
      .out_ready  (id_ready_i),
      .out_valid  (inst_valid_o),
      .out_data   ({inst_o, inst_pc_o}),
      .skid_valid (skid_valid)
   );
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: scoreboard of expected decode transfers plus timing checks.
module tb_if_fetch;
   import cpu_defs_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              rom_ce_o;
   logic [ROM_AW-1:0] rom_addr_o;
   logic [INST_W-1:0] rom_data_i;
   logic              flush_i;
   logic [PC_W-1:0]   flush_pc_i;
   logic [INST_W-1:0] inst_o;
   logic [PC_W-1:0]   inst_pc_o;
   logic              inst_valid_o;
   logic              id_ready_i;

   int n_chk  = 0;
   int n_fail = 0;
   int n_fire = 0;
   fetch_pkt_t exp_q[$];

   if_fetch dut (
      .clk(clk), .rst(rst), .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o),
      .rom_data_i(rom_data_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
      .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o),
      .id_ready_i(id_ready_i)
   );

   always #5 clk = ~clk;

   // ROM model: word k holds 32'h1000_0000+k; garbage when not enabled
   always @(posedge clk)
      rom_data_i <= rom_ce_o ? (32'h1000_0000 + 32'(rom_addr_o)) : $urandom;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
      end
   endtask

   function automatic fetch_pkt_t mk(input logic [31:0] pc);
      fetch_pkt_t p;
      p.pc   = pc;
      p.inst = 32'h1000_0000 + 32'((pc >> 2) & 32'h3FF);
      return p;
   endfunction

   // monitor: every transfer to decode must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && inst_valid_o && id_ready_i) begin
         fetch_pkt_t e;
         n_fire++;
         if (exp_q.size() == 0) begin
            chk("unexpected_fire_pc", inst_pc_o, 32'hDEAD_BEEF);
         end else begin
            e = exp_q.pop_front();
            chk("fire_pc", inst_pc_o, e.pc);
            chk("fire_inst", inst_o, e.inst);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; flush_i = 1'b0; flush_pc_i = '0; id_ready_i = 1'b0;
      repeat (3) step();
      #1;
      chk("rst_valid", 32'(inst_valid_o), 0);
      chk("rst_ce", 32'(rom_ce_o), 0);
      chk("rst_addr", 32'(rom_addr_o), 0);
      chk("rst_inst", inst_o, 0);
      chk("rst_pc", inst_pc_o, 0);

      // expected transfers in program order, hand-derived from the cycle plan
      for (int k = 0; k < 8; k++) exp_q.push_back(mk(32'(4 * k)));
      for (int k = 0; k < 4; k++) exp_q.push_back(mk(32'h40 + 32'(4 * k)));
      exp_q.push_back(mk(32'hFFC));
      exp_q.push_back(mk(32'h1000));
      exp_q.push_back(mk(32'h1004));
      for (int k = 0; k < 4; k++) exp_q.push_back(mk(32'(4 * k)));

      for (int c = 0; c <= 40; c++) begin
         step();
         rst        = (c == 29 || c == 30);
         id_ready_i = !((c >= 6 && c <= 10) || (c >= 15 && c <= 17) || c >= 37);
         flush_i    = (c == 17 || c == 23);
         flush_pc_i = (c == 17) ? 32'h0000_0043 : (c == 23) ? 32'h0000_0FFC : 32'h0;
         #1;
         if (c <= 3) begin
            chk("stream_ce", 32'(rom_ce_o), 1);
            chk("stream_addr", 32'(rom_addr_o), 32'(c));
         end
         if (c == 1) chk("first_valid_lat_lo", 32'(inst_valid_o), 0);
         if (c == 2) chk("first_valid_lat_hi", 32'(inst_valid_o), 1);
         if (c == 6) chk("stall_ce_low", 32'(rom_ce_o), 0);
         if (c >= 6 && c <= 10) begin
            chk("stall_valid", 32'(inst_valid_o), 1);
            chk("stall_pc_stable", inst_pc_o, 32'h10);
            chk("stall_inst_stable", inst_o, 32'h1000_0004);
         end
         if (c == 7) chk("stall_no_issue", 32'(rom_ce_o), 0);
         if (c == 11) chk("release_addr", 32'(rom_addr_o), 6);
         if (c == 17) chk("flush_no_issue", 32'(rom_ce_o), 0);
         if (c == 18) begin
            chk("flush_valid_lo", 32'(inst_valid_o), 0);
            chk("flush_ce", 32'(rom_ce_o), 1);
            chk("flush_target_addr", 32'(rom_addr_o), 16);
         end
         if (c == 19) chk("flush_valid_lo2", 32'(inst_valid_o), 0);
         if (c == 20) begin
            chk("flush_first_valid", 32'(inst_valid_o), 1);
            chk("flush_first_pc", inst_pc_o, 32'h40);
         end
         if (c == 24) begin
            chk("wrap_valid_lo", 32'(inst_valid_o), 0);
            chk("wrap_addr_top", 32'(rom_addr_o), 1023);
         end
         if (c == 25) chk("wrap_addr_zero", 32'(rom_addr_o), 0);
         if (c == 29) chk("midrst_ce", 32'(rom_ce_o), 0);
         if (c == 30) begin
            chk("midrst_valid", 32'(inst_valid_o), 0);
            chk("midrst_ce2", 32'(rom_ce_o), 0);
            chk("midrst_inst", inst_o, 0);
            chk("midrst_pc", inst_pc_o, 0);
         end
         if (c == 31) begin
            chk("restart_valid_lo", 32'(inst_valid_o), 0);
            chk("restart_addr", 32'(rom_addr_o), 0);
            chk("restart_ce", 32'(rom_ce_o), 1);
         end
         if (c == 33) chk("restart_first_pc", inst_pc_o, 0);
      end

      @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      chk("fire_count", 32'(n_fire), 19);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
